wb_wavesynth: RTL
=================

Name: wb_wavesynth

Overview:
- Wishbone classic slave behind the I/O interconnect, in the 16-byte audio window (four 32-bit registers).
- CPU pushes 8-bit unsigned audio samples into a sample FIFO.
- A prescaled 8-bit PWM engine consumes one sample per PWM period and drives the board's mono PWM audio pin.
- Provides status and a low-watermark interrupt so firmware can stream audio without tight polling.

Parameters:
FIFO_AW, 4, log2 of sample FIFO depth (default depth 16); legal 2..8
DEF_PRESCALE, 8'd0, reset value of CTRL.prescale

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  32  byte address; only bits [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; ignored, all writes full-word
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  ignored (classic cycles only)
wb_bte_i  in  2  ignored
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  constant 0
wb_rty_o  out  1  constant 0
pwm_o  out  1  PWM audio output
pwm_en_o  out  1  amplifier enable = CTRL.enable
irq_o  out  1  level interrupt

Behaviour:
- Reset (synchronous, active-high, wb_clk_i): all outputs 0; FIFO empty; CTRL = {prescale=DEF_PRESCALE, thresh=0, enable=0}; sticky flags 0; current sample 0; PWM counter 0; prescale counter 0.
- Reset mid-transfer: drops any pending ack and discards FIFO contents.
- Bus handshake:
  - wb_ack_o asserts one cycle after cyc&stb&!ack and stays high exactly one cycle.
  - Request still asserted in the ack cycle is not re-acked; the next access acks at the earliest two cycles later.
  - Register write side effects occur on the ack cycle only; wb_dat_o is valid during the ack cycle.
- Register map (adr[3:2]):
  - 0 CTRL rw: [0] enable, [1] flush (self-clearing, reads 0), [15:8] prescale, [23:16] thresh.
  - 1 STATUS: [8:0] fifo level, [9] empty, [10] full, [16] underrun sticky, [17] overflow sticky. Write 1 to bit 16 or 17 clears it.
  - 2 SAMPLE wo: write pushes wb_dat_i[7:0]. Reads return 0.
  - 3 CUR ro: [7:0] sample currently being played.
- FIFO:
  - Push on SAMPLE write when not full; write while full drops the sample and sets overflow.
  - Push and pop in the same cycle: level unchanged; both take effect.
  - flush=1: level 0 the cycle after ack. Flush wins over a same-cycle pop; CUR keeps its value.
- PWM engine, active only when enable=1:
  - tick fires every (prescale+1) clocks; prescale=0 gives a tick every clock.
  - pwm_cnt (8 bit) increments on tick, wrapping 255->0.
  - pwm_o = enable & (pwm_cnt < cur_sample), registered. Sample 0 gives constant low; sample 255 gives high 255/256 of the period.
  - On the tick where pwm_cnt wraps 255->0: if the FIFO is non-empty, pop into cur_sample. If empty, hold cur_sample and set underrun.
- enable=0: prescale counter and pwm_cnt are held at 0; pwm_o = 0; no pops; FIFO is still writable.
- Enable rising: the first pop occurs at the first wrap, 256*(prescale+1) clocks later.
- CTRL write changing prescale: takes effect at the next tick boundary; the prescale counter is not reset.
- irq_o = enable & (level <= thresh) & !(underrun masking none); registered, updates one cycle after a level change.
- Level arithmetic: FIFO_AW+1 bits, zero-extended into STATUS[8:0].

Test Plan:
- Reset, then read all four registers -> CTRL=0x00000000 (DEF_PRESCALE=0), STATUS=0x00000200 (empty), CUR=0; pwm_o=0, irq_o=0; each ack exactly one cycle wide.
- Push 0x40 and 0x80, prescale=0, enable=1 -> first pop at clock 256 after enable, CUR=0x40; pwm_o high 64 of 256 clocks per period. Next period CUR=0x80 with 128 high clocks.
- Enable with an empty FIFO -> after one period STATUS[16]=1 and CUR=0. Write 0x00010000 to STATUS -> bit 16 reads 0.
- Push 17 samples (FIFO_AW=4) with enable=0 -> level=16, full=1, overflow=1; the 17th sample is absent after draining.
- thresh=2, 5 samples queued, enable=1, prescale=1 -> irq_o rises one cycle after level drops to 2 (third pop, about 1536 clocks). Flush -> level 0, irq_o stays high.
- Assert wb_rst_i while a SAMPLE write is pending ack -> no ack, level 0, pwm_o low next cycle.

Source files
------------

// File: rtl/wb_wavesynth.sv
// Wishbone classic audio slave: CPU-fed 8-bit sample FIFO drained by a prescaled
// 8-bit PWM engine, one sample per PWM period, with status and low-watermark IRQ.
module wb_wavesynth #(
   parameter int         FIFO_AW      = 4,
   parameter logic [7:0] DEF_PRESCALE = 8'd0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic        pwm_o,
   output logic        pwm_en_o,
   output logic        irq_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
   localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_STATUS = 2'd1,
      REG_SAMPLE = 2'd2,
      REG_CUR    = 2'd3
   } reg_e;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               enable_q, enable_d;
   logic [7:0]         prescale_q, prescale_d;
   logic [7:0]         thresh_q, thresh_d;
   logic               unr_q, unr_d, ovf_q, ovf_d;
   logic [7:0]         cur_q, cur_d;
   logic [7:0]         pwm_cnt_q, pwm_cnt_d;
   logic [7:0]         presc_cnt_q, presc_cnt_d;
   logic               pwm_q, pwm_d, irq_q, irq_d, ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;

   logic       req, wr, wr_ctrl, wr_status, wr_sample, flush;
   logic       empty, full, tick, wrap, push, pop;
   logic [8:0] lvl9;
   reg_e       reg_sel;
   logic       unused_inputs;

   assign unused_inputs = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[31:4],
                            wb_adr_i[1:0], wb_dat_i[31:24]};

   // Register side effects are taken in the ack cycle, while the master still holds the request.
   assign req       = wb_cyc_i & wb_stb_i;
   assign reg_sel   = reg_e'(wb_adr_i[3:2]);
   assign wr        = req & ack_q & wb_we_i;
   assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
   assign wr_status = wr && (reg_sel == REG_STATUS);
   assign wr_sample = wr && (reg_sel == REG_SAMPLE);
   assign flush     = wr_ctrl & wb_dat_i[1];

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);
   assign lvl9  = 9'(level_q);

   // ">=" lets a lowered prescale end the current tick interval instead of waiting for an 8-bit wrap.
   assign tick = enable_q && (presc_cnt_q >= prescale_q);
   assign wrap = tick && (pwm_cnt_q == 8'hFF);
   assign push = wr_sample & ~full;
   assign pop  = wrap & ~empty & ~flush;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      ack_d       = req & ~ack_q;
      dat_d       = '0;
      enable_d    = wr_ctrl ? wb_dat_i[0]     : enable_q;
      prescale_d  = wr_ctrl ? wb_dat_i[15:8]  : prescale_q;
      thresh_d    = wr_ctrl ? wb_dat_i[23:16] : thresh_q;
      unr_d       = (unr_q & ~(wr_status & wb_dat_i[16])) | (wrap & empty);
      ovf_d       = (ovf_q & ~(wr_status & wb_dat_i[17])) | (wr_sample & full);
      cur_d       = pop ? mem_q[rd_ptr_q] : cur_q;
      level_d     = level_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      presc_cnt_d = 8'd0;
      pwm_cnt_d   = 8'd0;

      if (req & ~ack_q) begin
         unique case (reg_sel)
            REG_CTRL:   dat_d = {8'h00, thresh_q, prescale_q, 7'b0, enable_q};
            REG_STATUS: dat_d = {14'b0, ovf_q, unr_q, 5'b0, full, empty, lvl9};
            REG_SAMPLE: dat_d = '0;
            REG_CUR:    dat_d = {24'b0, cur_q};
         endcase
      end

      if (flush) begin
         level_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push & ~pop)      level_d = level_q + LVL_ONE;
         else if (pop & ~push) level_d = level_q - LVL_ONE;
      end

      if (enable_q && enable_d) begin
         presc_cnt_d = tick ? 8'd0 : presc_cnt_q + 8'd1;
         pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      end

      pwm_d = enable_q & (pwm_cnt_q < cur_q);
      irq_d = enable_q & (lvl9 <= {1'b0, thresh_q});
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q       <= 1'b0;
         dat_q       <= '0;
         enable_q    <= 1'b0;
         prescale_q  <= DEF_PRESCALE;
         thresh_q    <= 8'd0;
         unr_q       <= 1'b0;
         ovf_q       <= 1'b0;
         cur_q       <= 8'd0;
         level_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         presc_cnt_q <= 8'd0;
         pwm_cnt_q   <= 8'd0;
         pwm_q       <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         enable_q    <= enable_d;
         prescale_q  <= prescale_d;
         thresh_q    <= thresh_d;
         unr_q       <= unr_d;
         ovf_q       <= ovf_d;
         cur_q       <= cur_d;
         level_q     <= level_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         pwm_q       <= pwm_d;
         irq_q       <= irq_d;
      end
   end

   // NOTE: sample storage has no reset; the level and pointers alone define what is valid.
   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = 1'b0;
   assign wb_rty_o = 1'b0;
   assign pwm_o    = pwm_q;
   assign pwm_en_o = enable_q;
   assign irq_o    = irq_q;

endmodule
